// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered sync/coordinate/enable decodes.
// Define VGA_TIMING_RUNTIME_CFG_EN to accept new timing at run time, applied at a frame boundary.
module vga_timing_gen #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned FRAME_CNT_W  = 16,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 752,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 492,
  parameter int unsigned V_TOTAL      = 525,
  parameter logic        H_SYNC_POL   = 1'b0,
  parameter logic        V_SYNC_POL   = 1'b0
) (
  input  logic                   pixel_clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [COORD_W-1:0]     cfg_h_active,
  input  logic [COORD_W-1:0]     cfg_h_sync_start,
  input  logic [COORD_W-1:0]     cfg_h_sync_end,
  input  logic [COORD_W-1:0]     cfg_h_total,
  input  logic [COORD_W-1:0]     cfg_v_active,
  input  logic [COORD_W-1:0]     cfg_v_sync_start,
  input  logic [COORD_W-1:0]     cfg_v_sync_end,
  input  logic [COORD_W-1:0]     cfg_v_total,
  output logic                   cfg_applied,
  output logic                   hsync,
  output logic                   vsync,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic                   display_on,
  output logic                   line_tick,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  typedef struct packed {
    logic [COORD_W-1:0] h_active;
    logic [COORD_W-1:0] h_sync_start;
    logic [COORD_W-1:0] h_sync_end;
    logic [COORD_W-1:0] h_total;
    logic [COORD_W-1:0] v_active;
    logic [COORD_W-1:0] v_sync_start;
    logic [COORD_W-1:0] v_sync_end;
    logic [COORD_W-1:0] v_total;
  } timing_t;

  localparam timing_t P_TIMING = '{
    h_active:     COORD_W'(H_ACTIVE),
    h_sync_start: COORD_W'(H_SYNC_START),
    h_sync_end:   COORD_W'(H_SYNC_END),
    h_total:      COORD_W'(H_TOTAL),
    v_active:     COORD_W'(V_ACTIVE),
    v_sync_start: COORD_W'(V_SYNC_START),
    v_sync_end:   COORD_W'(V_SYNC_END),
    v_total:      COORD_W'(V_TOTAL)
  };

  timing_t live;

  logic [COORD_W-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic display_on_q, display_on_d;
  logic line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;
  logic h_last, v_last, frame_wrap, h_in_sync, v_in_sync;

  always_comb begin
    h_last        = (h_cnt_q == live.h_total - COORD_W'(1));
    v_last        = (v_cnt_q == live.v_total - COORD_W'(1));
    frame_wrap    = en && h_last && v_last;
    h_in_sync     = (h_cnt_q >= live.h_sync_start) && (h_cnt_q < live.h_sync_end);
    v_in_sync     = (v_cnt_q >= live.v_sync_start) && (v_cnt_q < live.v_sync_end);

    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_count_d = frame_count_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + COORD_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + COORD_W'(1);
    end
    if (frame_wrap) frame_count_d = frame_count_q + FRAME_CNT_W'(1);

    // Decodes look at the current count, so every output lags the counters by one cycle.
    x_d          = h_cnt_q;
    y_d          = v_cnt_q;
    hsync_d      = (en && h_in_sync) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d      = (en && v_in_sync) ? V_SYNC_POL : ~V_SYNC_POL;
    display_on_d = en && (h_cnt_q < live.h_active) && (v_cnt_q < live.v_active);
    line_tick_d  = en && (h_cnt_q == '0);
    frame_tick_d = en && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      display_on_q  <= 1'b0;
      line_tick_q   <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_tick_q   <= line_tick_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

`ifdef VGA_TIMING_RUNTIME_CFG_EN
  timing_t live_q, live_d, pend_q, pend_d;
  logic pend_valid_q, pend_valid_d;
  logic apply_q, apply_d;
  logic cfg_ready_q, cfg_ready_d;
  logic cfg_applied_q, cfg_applied_d;
  logic capture, apply_wrap, apply_idle;

  always_comb begin
    capture    = cfg_valid && cfg_ready_q;
    // pend_valid_q is still low on a capture cycle, so a coinciding wrap waits a frame.
    apply_wrap = pend_valid_q && frame_wrap;
    apply_idle = pend_valid_q && !en;

    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    live_d       = live_q;
    if (capture) begin
      pend_d       = '{cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
                       cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total};
      pend_valid_d = 1'b1;
    end else if (apply_wrap || apply_idle) begin
      live_d       = pend_q;
      pend_valid_d = 1'b0;
    end

    // A wrap apply is reported two cycles on, lining up with frame_tick of the new frame.
    apply_d       = apply_wrap;
    cfg_applied_d = apply_q || apply_idle;
    cfg_ready_d   = cfg_ready_q;
    if (capture)                      cfg_ready_d = 1'b0;
    else if (apply_q || apply_idle)   cfg_ready_d = 1'b1;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q        <= P_TIMING;
      pend_q        <= P_TIMING;
      pend_valid_q  <= 1'b0;
      apply_q       <= 1'b0;
      cfg_ready_q   <= 1'b1;
      cfg_applied_q <= 1'b0;
    end else begin
      live_q        <= live_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      apply_q       <= apply_d;
      cfg_ready_q   <= cfg_ready_d;
      cfg_applied_q <= cfg_applied_d;
    end
  end

  assign live        = live_q;
  assign cfg_ready   = cfg_ready_q;
  assign cfg_applied = cfg_applied_q;
`else
  logic unused_cfg;

  assign live        = P_TIMING;
  assign cfg_ready   = 1'b0;
  assign cfg_applied = 1'b0;
  assign unused_cfg  = ^{cfg_valid, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
                         cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total};
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign x           = x_q;
  assign y           = y_q;
  assign display_on  = display_on_q;
  assign line_tick   = line_tick_q;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small raster on the main instance, default raster with
// inverted polarity on a second instance; runtime-cfg cases follow VGA_TIMING_RUNTIME_CFG_EN.
module tb_vga_timing_gen;

  localparam int unsigned CW = 10;
  localparam int unsigned FW = 16;

  logic          clk = 1'b0;
  logic          reset_n, en, en_p, cfg_valid;
  logic [CW-1:0] c_ha, c_hss, c_hse, c_ht, c_va, c_vss, c_vse, c_vt;
  logic          cfg_ready, cfg_applied, hsync, vsync, display_on, line_tick, frame_tick;
  logic [CW-1:0] x, y;
  logic [FW-1:0] frame_count;
  logic          p_ready, p_applied, p_hsync, p_vsync, p_disp, p_lt, p_ft;
  logic [CW-1:0] p_x, p_y;
  logic [FW-1:0] p_fc;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  // Small raster: 25 x 15, active 16 x 10, hsync 18..21, vsync lines 11..12.
  vga_timing_gen #(
    .COORD_W(CW), .FRAME_CNT_W(FW),
    .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_END(22), .H_TOTAL(25),
    .V_ACTIVE(10), .V_SYNC_START(11), .V_SYNC_END(13), .V_TOTAL(15)
  ) dut (
    .pixel_clk(clk), .reset_n(reset_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(c_ha), .cfg_h_sync_start(c_hss), .cfg_h_sync_end(c_hse), .cfg_h_total(c_ht),
    .cfg_v_active(c_va), .cfg_v_sync_start(c_vss), .cfg_v_sync_end(c_vse), .cfg_v_total(c_vt),
    .cfg_applied(cfg_applied), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .display_on(display_on), .line_tick(line_tick), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  vga_timing_gen #(
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_pol (
    .pixel_clk(clk), .reset_n(reset_n), .en(en_p),
    .cfg_valid(1'b0), .cfg_ready(p_ready),
    .cfg_h_active(c_ha), .cfg_h_sync_start(c_hss), .cfg_h_sync_end(c_hse), .cfg_h_total(c_ht),
    .cfg_v_active(c_va), .cfg_v_sync_start(c_vss), .cfg_v_sync_end(c_vse), .cfg_v_total(c_vt),
    .cfg_applied(p_applied), .hsync(p_hsync), .vsync(p_vsync), .x(p_x), .y(p_y),
    .display_on(p_disp), .line_tick(p_lt), .frame_tick(p_ft), .frame_count(p_fc)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int ha, input int hss, input int hse, input int ht,
                         input int va, input int vss, input int vse, input int vt);
    c_ha = CW'(ha); c_hss = CW'(hss); c_hse = CW'(hse); c_ht = CW'(ht);
    c_va = CW'(va); c_vss = CW'(vss); c_vse = CW'(vse); c_vt = CW'(vt);
  endtask

  initial begin
    int unsigned hs_low, vs_low, disp, ft, lt, bad, n, applied_n;
    int first_hs, first_vs, first_lt, spacing;
    int unsigned phs, pvs, pdisp, plt;
    logic [CW-1:0] px, py;
    logic found;

    reset_n = 1'b0; en = 1'b1; en_p = 1'b1; cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_hsync", hsync, 1);
    check_eq("rst_vsync", vsync, 1);
    check_eq("rst_display_on", display_on, 0);
    check_eq("rst_ticks", {line_tick, frame_tick}, 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_cfg_applied", cfg_applied, 0);
`ifdef VGA_TIMING_RUNTIME_CFG_EN
    check_eq("rst_cfg_ready", cfg_ready, 1);
`else
    check_eq("rst_cfg_ready", cfg_ready, 0);
`endif
    check_eq("pol_rst_hsync", p_hsync, 0);
    check_eq("pol_rst_vsync", p_vsync, 0);

    // Two small frames (750 cycles); the default-raster instance sees one full 800-pixel line.
    reset_n = 1'b1;
    hs_low = 0; vs_low = 0; disp = 0; ft = 0; lt = 0; first_hs = -1; first_vs = -1;
    phs = 0; pvs = 0; pdisp = 0; plt = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (i == 0) begin
        check_eq("first_x", x, 0);
        check_eq("first_y", y, 0);
        check_eq("first_frame_tick", frame_tick, 1);
      end
      if (i < 750) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (display_on) disp++;
        if (frame_tick) ft++;
        if (line_tick) lt++;
        if (!hsync && first_hs < 0) first_hs = int'(x);
        if (!vsync && first_vs < 0) first_vs = int'(y);
      end
      if (p_hsync) phs++;
      if (p_vsync) pvs++;
      if (p_disp) pdisp++;
      if (p_lt) plt++;
    end
    check_eq("hsync_low_cycles", hs_low, 120);
    check_eq("vsync_low_cycles", vs_low, 100);
    check_eq("display_on_cycles", disp, 320);
    check_eq("frame_ticks", ft, 2);
    check_eq("line_ticks", lt, 30);
    check_eq("hsync_first_x", first_hs, 18);
    check_eq("vsync_first_y", first_vs, 11);
    check_eq("frame_count_2", frame_count, 2);
    check_eq("pol_hsync_active", phs, 96);
    check_eq("pol_vsync_active", pvs, 0);
    check_eq("pol_display_on", pdisp, 640);
    check_eq("pol_line_ticks", plt, 1);

    // Enable toggle mid-line.
    for (int k = 0; k < 100 && x != CW'(12); k++) tick();
    check_eq("wait_x12", x, 12);
    en = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (hsync !== 1'b1 || vsync !== 1'b1 || display_on || line_tick || frame_tick) bad++;
    end
    check_eq("en_low_outputs", bad, 0);
    en = 1'b1;
    tick();
    check_eq("en_rise_x", x, 0);
    check_eq("en_rise_y", y, 0);
    check_eq("en_rise_frame_tick", frame_tick, 1);
    check_eq("en_frame_count_held", frame_count, 2);

`ifdef VGA_TIMING_RUNTIME_CFG_EN
    // Mid-frame capture: old timing runs to its end, then 100 x 50 goes live.
    for (int k = 0; k < 400 && y != CW'(5); k++) tick();
    set_cfg(80, 84, 92, 100, 40, 42, 44, 50);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_eq("cfg_ready_drop", cfg_ready, 0);
    found = 1'b0; ft = 0; px = x; py = y;
    for (int k = 0; k < 800 && !found; k++) begin
      px = x; py = y;
      tick();
      if (cfg_applied) found = 1'b1;
      else if (frame_tick) ft++;
    end
    check_eq("applied_seen", found, 1);
    check_eq("old_frame_no_early_tick", ft, 0);
    check_eq("old_frame_end_x", px, 24);
    check_eq("old_frame_end_y", py, 14);
    check_eq("applied_with_frame_tick", frame_tick, 1);
    check_eq("applied_ready_back", cfg_ready, 1);

    n = 0; hs_low = 0; vs_low = 0; disp = 0; applied_n = 0;
    do begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (display_on) disp++;
      if (cfg_applied) applied_n++;
      n++;
      tick();
    end while (!frame_tick && n < 6000);
    check_eq("new_frame_len", n, 5000);
    check_eq("new_hsync_low", hs_low, 400);
    check_eq("new_vsync_low", vs_low, 200);
    check_eq("new_display_on", disp, 3200);
    check_eq("new_applied_once", applied_n, 1);

    // Capture on the frame-wrap cycle itself: one full old frame elapses first.
    for (int k = 0; k < 6000 && !(x == CW'(98) && y == CW'(49)); k++) tick();
    check_eq("wait_wrap", {x, y}, {CW'(98), CW'(49)});
    set_cfg(20, 22, 26, 30, 12, 14, 16, 20);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_eq("wrap_ready_drop", cfg_ready, 0);
    tick();
    check_eq("wrap_frame_tick", frame_tick, 1);
    check_eq("wrap_not_applied", cfg_applied, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cfg_applied && n < 6000);
    check_eq("wrap_apply_delay", n, 5000);
    n = 0;
    do begin
      n++;
      tick();
    end while (!frame_tick && n < 1000);
    check_eq("wrap_new_frame_len", n, 600);

    // Apply while disabled: immediate.
    en = 1'b0;
    set_cfg(80, 84, 92, 100, 40, 42, 44, 50);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_eq("idle_applied_early", cfg_applied, 0);
    check_eq("idle_ready_drop", cfg_ready, 0);
    tick();
    check_eq("idle_applied", cfg_applied, 1);
    check_eq("idle_ready_back", cfg_ready, 1);
    en = 1'b1;
    tick();
    n = 0;
    do begin
      n++;
      tick();
    end while (!line_tick && n < 300);
    check_eq("idle_line_len", n, 100);

    // Reset with a capture pending.
    set_cfg(20, 22, 26, 30, 12, 14, 16, 20);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_eq("rst_hs_ready_drop", cfg_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_hs_ready", cfg_ready, 1);
    check_eq("rst_hs_applied", cfg_applied, 0);
    @(negedge clk);
    reset_n = 1'b1;
    applied_n = 0; first_lt = -1; spacing = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (cfg_applied) applied_n++;
      if (line_tick) begin
        if (first_lt < 0) first_lt = i;
        else if (spacing == 0) spacing = i - first_lt;
      end
    end
    check_eq("rst_hs_no_apply", applied_n, 0);
    check_eq("rst_hs_line_len", spacing, 25);
`else
    // Without runtime cfg the handshake outputs stay low and the raster is unaffected.
    set_cfg(80, 84, 92, 100, 40, 42, 44, 50);
    cfg_valid = 1'b1;
    bad = 0; ft = 0;
    for (int i = 0; i < 375; i++) begin
      tick();
      if (cfg_ready || cfg_applied) bad++;
      if (frame_tick) ft++;
    end
    cfg_valid = 1'b0;
    check_eq("nocfg_handshake_low", bad, 0);
    check_eq("nocfg_frame_ticks", ft, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: second-generation pixel/line counter that drives sync, coordinates and display-enable for the renderer in the `pixel_clk` domain. It supports compile-time timing defaults, selectable sync polarity, a frame counter, line/frame strobes, and a synchronous run enable. Optionally, it accepts new timing at run time through a valid/ready handshake, applied only at a frame boundary.

## Interface
- Clock: one clock, `pixel_clk`. Reset: `reset_n`, asynchronous, active-low.

Parameters:
- `COORD_W`, 10: width of counters, coordinates and timing values.
- `FRAME_CNT_W`, 16: frame counter width.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_SYNC_START`, 656: h count at which hsync asserts.
- `H_SYNC_END`, 752: h count at which hsync deasserts.
- `H_TOTAL`, 800: pixels per line.
- `V_ACTIVE`, 480: visible lines.
- `V_SYNC_START`, 490: v count at which vsync asserts.
- `V_SYNC_END`, 492: v count at which vsync deasserts.
- `V_TOTAL`, 525: lines per frame.
- `H_SYNC_POL`, 0: active level of hsync (0 = active-low).
- `V_SYNC_POL`, 0: active level of vsync (0 = active-low).

Ports:
- `pixel_clk`, in, 1: pixel clock.
- `reset_n`, in, 1: async active-low reset.
- `en`, in, 1: run enable.
- `cfg_valid`, in, 1: new timing offered.
- `cfg_ready`, out, 1: block can accept timing.
- `cfg_h_active`, `cfg_h_sync_start`, `cfg_h_sync_end`, `cfg_h_total`, in, COORD_W each: horizontal timing.
- `cfg_v_active`, `cfg_v_sync_start`, `cfg_v_sync_end`, `cfg_v_total`, in, COORD_W each: vertical timing.
- `cfg_applied`, out, 1: one-cycle pulse when pending timing becomes live.
- `hsync`, `vsync`, out, 1: sync outputs at the configured polarity.
- `x`, `y`, out, COORD_W: current counter position.
- `display_on`, out, 1: pixel is in the active area.
- `line_tick`, out, 1: one-cycle pulse at the start of each line.
- `frame_tick`, out, 1: one-cycle pulse at the start of each frame.
- `frame_count`, out, FRAME_CNT_W: completed frame count, wraps.

## Operation
- Internal `h_cnt`/`v_cnt` run 0..total-1 on the live timing set, which is initialised from the parameters at reset.
- `h_cnt` wraps at `h_total-1`. On that wrap, `v_cnt` increments, or wraps at `v_total-1`.
- Frame wrap occurs when `h_cnt==h_total-1` and `v_cnt==v_total-1`. On a frame wrap, `frame_count` increments modulo 2^FRAME_CNT_W.
- Output decodes, all registered from the counter values:
  - hsync active iff `h_sync_start <= h_cnt < h_sync_end`; vsync active iff the same test holds on `v_cnt`.
  - `display_on` = `(h_cnt < h_active) && (v_cnt < v_active)`.
  - `x` = `h_cnt`, `y` = `v_cnt`, over the full range; consumers gate on `display_on`.
  - `line_tick` = `(h_cnt==0)`; `frame_tick` = `(h_cnt==0 && v_cnt==0)`.
- `en` low, applied synchronously:
  - counters clear to 0;
  - hsync/vsync go to their inactive level; `display_on`, `line_tick` and `frame_tick` go to 0;
  - `frame_count` holds.
  - When `en` returns high, the first output cycle reflects (0,0), so `frame_tick` fires.
- Timing values are not range-checked. The caller guarantees `active <= sync_start < sync_end <= total` and `total >= 2`.
- Reset values:
  - counters 0; `x`, `y`, `frame_count` 0;
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL;
  - `display_on`, `line_tick`, `frame_tick`, `cfg_applied` 0;
  - `cfg_ready` 1 when the macro below is defined, else 0.

## Timing
- Latency is 1 cycle: outputs in cycle n+1 reflect counter state in cycle n. All outputs are aligned with each other.
- Sync pulse width equals `sync_end - sync_start` pixels (hsync) or lines (vsync). vsync edges coincide with hsync-cycle boundaries at `h_cnt==0`.
- Handshake:
  - A transfer occurs on a cycle with `cfg_valid && cfg_ready`. All eight cfg values are captured into a pending register and `cfg_ready` drops on the next cycle.
  - Pending timing becomes live on the frame-wrap cycle in which `en` is high. The counters load 0, `cfg_applied` pulses 1 cycle later (aligned with `frame_tick`), and `cfg_ready` returns high in that same cycle.
  - A capture on the same cycle as a frame wrap is not applied until the next frame wrap.
  - With `en` low, pending timing is applied immediately on the next cycle: `cfg_applied` pulses and `cfg_ready` rises.
- `reset_n` asserted mid-frame or mid-handshake discards pending timing and restores the parameter timing asynchronously.

## Configuration
- Macro: `VGA_TIMING_RUNTIME_CFG_EN`.
- Defined: pending/live timing registers and the handshake behave as above.
- Undefined:
  - live timing is the parameter constants; no timing registers exist;
  - `cfg_ready` and `cfg_applied` are tied to 0; `cfg_*` inputs are ignored;
  - all other behaviour is identical.

## Test plan
- Reset and default parameters, `en`=1 for 2 frames:
  - hsync low for exactly 96 clocks per 800-clock line;
  - vsync low for 2 lines per 525-line frame;
  - `display_on` count = 307200 per frame;
  - `frame_count` reads 2.
- Polarity: with `H_SYNC_POL`=1 and `V_SYNC_POL`=1, sync outputs are inverted and their reset value is 0.
- Runtime cfg (macro on): mid-frame, send `h_total`=100, `v_total`=50 (active 80/40, sync 84..92 / 42..44).
  - `cfg_ready` drops and old timing continues to the frame end.
  - `cfg_applied` and `frame_tick` then pulse together, and the next frame is 5000 clocks.
- Frame-wrap coincidence: assert `cfg_valid` exactly on a frame-wrap cycle → the new timing is live only after the following frame (one full old frame elapses).
- Enable toggle: drop `en` at `h_cnt`=300, hold 10 cycles, raise it.
  - syncs are inactive and `display_on` is 0 while `en` is low;
  - `frame_tick` fires on the first enabled output cycle with x=0, y=0;
  - `frame_count` is unchanged.
- Reset mid-handshake: capture a cfg, then pulse `reset_n` low → `cfg_ready`=1, no `cfg_applied`, and line length reverts to 800.
